// File: rtl/ev20_seq_pkg.sv
// ev20 sequencer shared definitions.
// Opcodes, FSM states and the idle ALU select.
package ev20_seq_pkg;

  localparam logic [3:0] OP_PASS_A = 4'h0;
  localparam logic [3:0] OP_PASS_B = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_ADC    = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_SBB    = 4'h7;
  localparam logic [3:0] OP_XOR    = 4'h8;
  localparam logic [3:0] OP_NOT    = 4'h9;
  localparam logic [3:0] OP_ONES   = 4'hA;
  localparam logic [3:0] OP_CLRC   = 4'hB;
  localparam logic [3:0] OP_SETC   = 4'hC;
  localparam logic [3:0] OP_JMP    = 4'hD;
  localparam logic [3:0] OP_JC     = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [3:0] ALU_IDLE_SEL = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALTED
  } seq_state_t;

endpackage

// File: rtl/seq_decode.sv
// ev20 opcode decoder.
// Pure combinational opcode to control mapping.
module seq_decode
  import ev20_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [3:0] alu_sel,
  output logic       acc_we,
  output logic       cy_we,
  output logic       is_jmp,
  output logic       is_jc,
  output logic       is_halt
);

  // Control-flow opcodes first; everything else is an ALU op.
  always_comb begin
    alu_sel = ALU_IDLE_SEL;
    acc_we  = 1'b0;
    cy_we   = 1'b0;
    is_jmp  = 1'b0;
    is_jc   = 1'b0;
    is_halt = 1'b0;
    unique case (1'b1)
      (opcode == OP_HALT): is_halt = 1'b1;
      (opcode == OP_JC):   is_jc   = 1'b1;
      (opcode == OP_JMP):  is_jmp  = 1'b1;
      default: begin
        alu_sel = opcode;
        acc_we  = (opcode <= OP_ONES);
        cy_we   = (opcode != OP_NOT) &&
                  (opcode != OP_ONES);
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ev20 fetch/decode/execute sequencer.
// Drives the registered 16-bit ALU and owns ACC/Cy.
module alu_sequencer
  import ev20_seq_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              System_Clk,
  input  logic              System_Rst_n,
  input  logic              Run,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Rd,
  input  logic              Mem_Ack,
  input  logic [15:0]       Mem_Data,
  output logic [3:0]        ALU_Sel,
  output logic [15:0]       Op_A,
  output logic [15:0]       Op_B,
  output logic              Cy_Flag,
  input  logic [15:0]       ALU_Out,
  input  logic              CY_Out,
  output logic [15:0]       Acc,
  output logic              Halted
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       acc_q, acc_d;
  logic              cy_q, cy_d;
  logic [3:0]        sel_q, sel_d;
  logic [15:0]       opa_q, opa_d;
  logic [15:0]       opb_q, opb_d;

  logic [3:0] dec_sel;
  logic       dec_acc_we;
  logic       dec_cy_we;
  logic       dec_jmp;
  logic       dec_jc;
  logic       dec_halt;

  logic [ADDR_W-1:0] imm_pc;

  seq_decode u_dec (
    .opcode  (ir_q[15:12]),
    .alu_sel (dec_sel),
    .acc_we  (dec_acc_we),
    .cy_we   (dec_cy_we),
    .is_jmp  (dec_jmp),
    .is_jc   (dec_jc),
    .is_halt (dec_halt)
  );

  assign imm_pc = ADDR_W'(ir_q[11:0]);

  // Next state, PC/IR update, operand latch and write-back.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    sel_d   = sel_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    unique case (state_q)
      IDLE: begin
        if (Run) state_d = FETCH;
      end
      FETCH: begin
        if (Mem_Ack) begin
          ir_d    = Mem_Data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          dec_halt: state_d = HALTED;
          dec_jmp: begin
            pc_d    = imm_pc;
            state_d = FETCH;
          end
          dec_jc: begin
            if (cy_q) pc_d = imm_pc;
            state_d = FETCH;
          end
          default: begin
            sel_d   = dec_sel;
            opa_d   = acc_q;
            opb_d   = {4'h0, ir_q[11:0]};
            state_d = EXEC;
          end
        endcase
      end
      EXEC: state_d = WB;
      WB: begin
        if (dec_acc_we) acc_d = ALU_Out;
        if (dec_cy_we)  cy_d  = CY_Out;
        sel_d   = ALU_IDLE_SEL;
        opa_d   = '0;
        opb_d   = '0;
        state_d = FETCH;
      end
      HALTED: begin
        if (Run) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Architectural and ALU-drive registers.
  always_ff @(posedge System_Clk or negedge System_Rst_n) begin
    if (!System_Rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      sel_q   <= ALU_IDLE_SEL;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      sel_q   <= sel_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign Mem_Addr = pc_q;
  assign Mem_Rd   = (state_q == FETCH);
  assign ALU_Sel  = sel_q;
  assign Op_A     = opa_q;
  assign Op_B     = opb_q;
  assign Cy_Flag  = cy_q;
  assign Acc      = acc_q;
  assign Halted   = (state_q == HALTED);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: memory responder, model ALU,
// ISA-level reference model and random programs.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Run = 1'b0;
  logic [11:0] Mem_Addr;
  logic        Mem_Rd;
  logic        Mem_Ack = 1'b0;
  logic [15:0] Mem_Data = 16'hF000;
  logic [3:0]  ALU_Sel;
  logic [15:0] Op_A, Op_B;
  logic        Cy_Flag;
  logic [15:0] ALU_Out = 16'h0;
  logic        CY_Out = 1'b0;
  logic [15:0] Acc;
  logic        Halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:4095];
  int          ack_delay  = 0;
  int          stall_addr = -1;
  logic        spur_ack   = 1'b0;
  int          rdcnt      = 0;
  int          ncyc       = 0;

  logic [11:0] fetch_q[$];
  int          cyc_q[$];
  int          len_q[$];

  logic [11:0] ref_q[$];
  logic [15:0] m_acc;
  logic        m_cy;
  int          m_pc;

  alu_sequencer #(.ADDR_W(12)) dut (
    .System_Clk   (clk),
    .System_Rst_n (rst_n),
    .Run          (Run),
    .Mem_Addr     (Mem_Addr),
    .Mem_Rd       (Mem_Rd),
    .Mem_Ack      (Mem_Ack),
    .Mem_Data     (Mem_Data),
    .ALU_Sel      (ALU_Sel),
    .Op_A         (Op_A),
    .Op_B         (Op_B),
    .Cy_Flag      (Cy_Flag),
    .ALU_Out      (ALU_Out),
    .CY_Out       (CY_Out),
    .Acc          (Acc),
    .Halted       (Halted)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_f(
    input logic [3:0] s, input logic [15:0] a,
    input logic [15:0] b, input logic c);
    case (s)
      4'h0: return {1'b0, a};
      4'h1: return {1'b0, b};
      4'h2: return {1'b0, a & b};
      4'h3: return {1'b0, a | b};
      4'h4: return {1'b0, a} + {1'b0, b};
      4'h5: return {1'b0, a} + {1'b0, b} + 17'(c);
      4'h6: return {1'b0, a} - {1'b0, b};
      4'h7: return {1'b0, a} - {1'b0, b} - 17'(c);
      4'h8: return {1'b0, a ^ b};
      4'h9: return {1'b0, ~a};
      4'hA: return {1'b0, 16'hFFFF};
      4'hB: return {1'b0, a};
      4'hC: return {1'b1, a};
      default: return {1'b0, a};
    endcase
  endfunction

  // Registered model ALU.
  always @(posedge clk) begin
    {CY_Out, ALU_Out} <= alu_f(ALU_Sel, Op_A, Op_B, Cy_Flag);
    ncyc <= ncyc + 1;
  end

  // Program memory responder with programmable wait states.
  always @(negedge clk) begin
    if (Mem_Rd) begin
      rdcnt = rdcnt + 1;
      if (rdcnt > ack_delay && int'(Mem_Addr) != stall_addr) begin
        Mem_Ack  = 1'b1;
        Mem_Data = mem[Mem_Addr];
        fetch_q.push_back(Mem_Addr);
        cyc_q.push_back(ncyc);
        len_q.push_back(rdcnt);
        rdcnt = 0;
      end else begin
        Mem_Ack  = 1'b0;
        Mem_Data = 16'hF000;
      end
    end else begin
      rdcnt    = 0;
      Mem_Ack  = spur_ack;
      Mem_Data = 16'hF000;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    Run        = 1'b0;
    spur_ack   = 1'b0;
    stall_addr = -1;
    ack_delay  = 0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    fetch_q.delete();
    cyc_q.delete();
    len_q.delete();
  endtask

  task automatic start_run();
    Run = 1'b1;
    cyc();
    Run = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!Halted && n < 2000) begin
      cyc();
      n++;
    end
    check({tag, "_halt"}, 32'(Halted), 1);
  endtask

  task automatic ref_run();
    int          pc = 0;
    logic [15:0] acc = 16'h0;
    logic        cy = 1'b0;
    logic [15:0] ins;
    logic [3:0]  op;
    logic [11:0] imm;
    logic [16:0] r;
    ref_q.delete();
    for (int step = 0; step < 2000; step++) begin
      ref_q.push_back(12'(pc));
      ins = mem[pc];
      pc  = (pc + 1) % 4096;
      op  = ins[15:12];
      imm = ins[11:0];
      if (op <= 4'hC) begin
        r = alu_f(op, acc, {4'h0, imm}, cy);
        if (op <= 4'hA) acc = r[15:0];
        if (op <= 4'h8 || op >= 4'hB) cy = r[16];
      end else if (op == 4'hD) begin
        pc = int'(imm);
      end else if (op == 4'hE) begin
        if (cy) pc = int'(imm);
      end else begin
        break;
      end
    end
    m_acc = acc;
    m_cy  = cy;
    m_pc  = pc;
  endtask

  task automatic gen_prog(input int base, input int len);
    logic [3:0]  op;
    logic [11:0] imm;
    int          tgt;
    for (int i = 0; i < len - 1; i++) begin
      op  = 4'($urandom_range(0, 14));
      imm = 12'($urandom);
      if (op == 4'hD || op == 4'hE) begin
        tgt = base + i + 1 + $urandom_range(0, len - 2 - i);
        imm = 12'(tgt);
      end
      mem[base + i] = {op, imm};
    end
    mem[base + len - 1] = 16'hF000;
    mem[0] = {4'hD, 12'(base)};
  endtask

  task automatic cmp_ref(input string tag);
    ref_run();
    check({tag, "_nfetch"}, 32'(fetch_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < fetch_q.size(); i++)
      check({tag, "_faddr"}, 32'(fetch_q[i]), 32'(ref_q[i]));
    check({tag, "_acc"}, 32'(Acc), 32'(m_acc));
    check({tag, "_cy"}, 32'(Cy_Flag), 32'(m_cy));
    check({tag, "_pc"}, 32'(Mem_Addr), 32'(m_pc));
  endtask

  initial begin
    int base;
    int len;
    int n;
    int hc;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    clear_mem();
    do_reset();

    // Reset / idle with spurious acks.
    for (int i = 0; i < 10; i++) begin
      spur_ack = (i >= 3 && i < 6);
      cyc();
    end
    spur_ack = 1'b0;
    check("idle_rd", 32'(Mem_Rd), 0);
    check("idle_sel", 32'(ALU_Sel), 32'h8);
    check("idle_acc", 32'(Acc), 0);
    check("idle_halt", 32'(Halted), 0);
    check("idle_opab", 32'({Op_A, Op_B}), 0);
    check("idle_pc", 32'(Mem_Addr), 0);
    check("idle_nf", 32'(fetch_q.size()), 0);

    // ADD immediate, cycle by cycle.
    clear_mem();
    mem[0] = 16'h1003;
    mem[1] = 16'h4005;
    do_reset();
    start_run();
    n = 0;
    while (fetch_q.size() < 2 && n < 50) begin
      cyc();
      n++;
    end
    check("add_f1", 32'(fetch_q.size()), 2);
    check("add_f1pc", 32'(Mem_Addr), 1);
    cyc();
    check("add_dec_pc", 32'(Mem_Addr), 2);
    cyc();
    check("add_ex_sel", 32'(ALU_Sel), 32'h4);
    check("add_ex_b", 32'(Op_B), 32'h5);
    check("add_ex_a", 32'(Op_A), 32'h3);
    cyc();
    check("add_wb_sel", 32'(ALU_Sel), 32'h4);
    check("add_wb_b", 32'(Op_B), 32'h5);
    cyc();
    check("add_acc", 32'(Acc), 32'h8);
    check("add_cy", 32'(Cy_Flag), 0);
    check("add_post_sel", 32'(ALU_Sel), 32'h8);
    check("add_post_b", 32'(Op_B), 0);
    check("add_4cyc", 32'(cyc_q[1] - cyc_q[0]), 4);
    wait_halt("add");

    // Carry then JC taken.
    clear_mem();
    mem[0] = 16'hA000;
    mem[1] = 16'hB000;
    mem[2] = 16'h4001;
    mem[3] = 16'hE020;
    do_reset();
    start_run();
    wait_halt("jc1");
    check("jc1_acc", 32'(Acc), 0);
    check("jc1_cy", 32'(Cy_Flag), 1);
    check("jc1_tgt", 32'(fetch_q[4]), 32'h20);
    check("jc1_2cyc", 32'(cyc_q[4] - cyc_q[3]), 2);

    // JC not taken.
    clear_mem();
    mem[0] = 16'hA000;
    mem[1] = 16'hB000;
    mem[2] = 16'h4000;
    mem[3] = 16'hE020;
    do_reset();
    start_run();
    wait_halt("jc0");
    check("jc0_acc", 32'(Acc), 32'hFFFF);
    check("jc0_cy", 32'(Cy_Flag), 0);
    check("jc0_next", 32'(fetch_q[4]), 32'h4);

    // Flag-only and constant-only ops.
    clear_mem();
    mem[0] = 16'h1123;
    mem[1] = 16'hC000;
    mem[3] = 16'hA000;
    do_reset();
    start_run();
    wait_halt("setc");
    check("setc_cy", 32'(Cy_Flag), 1);
    check("setc_acc", 32'(Acc), 32'h123);
    start_run();
    wait_halt("ones");
    check("ones_acc", 32'(Acc), 32'hFFFF);
    check("ones_cy", 32'(Cy_Flag), 1);

    // Three wait states per fetch.
    clear_mem();
    mem[0] = 16'h1077;
    mem[1] = 16'h2003;
    do_reset();
    ack_delay = 3;
    start_run();
    wait_halt("ws");
    check("ws_acc", 32'(Acc), 32'h3);
    check("ws_nf", 32'(len_q.size()), 3);
    foreach (len_q[i]) check("ws_rdlen", 32'(len_q[i]), 4);

    // PC wrap at 0xFFF and JC both ways.
    clear_mem();
    mem[0]     = 16'hE005;
    mem[1]     = 16'hDFFF;
    mem[12'hFFF] = 16'hC000;
    do_reset();
    start_run();
    wait_halt("wrap");
    check("wrap_nf", 32'(fetch_q.size()), 5);
    check("wrap_f2", 32'(fetch_q[2]), 32'hFFF);
    check("wrap_f3", 32'(fetch_q[3]), 0);
    check("wrap_f4", 32'(fetch_q[4]), 5);
    check("wrap_pc", 32'(Mem_Addr), 6);

    // Halt and resume.
    clear_mem();
    mem[0]     = 16'hD010;
    mem[12'h11] = 16'h1055;
    do_reset();
    start_run();
    wait_halt("hlt");
    hc = ncyc;
    check("hlt_f1", 32'(fetch_q[1]), 32'h10);
    check("hlt_rise", 32'(hc - cyc_q[1]), 2);
    check("jmp_2cyc", 32'(cyc_q[1] - cyc_q[0]), 2);
    check("hlt_pc", 32'(Mem_Addr), 32'h11);
    check("hlt_rd", 32'(Mem_Rd), 0);
    start_run();
    check("res_halt", 32'(Halted), 0);
    wait_halt("res");
    check("res_f2", 32'(fetch_q[2]), 32'h11);
    check("res_acc", 32'(Acc), 32'h55);

    // Reset asserted mid-fetch.
    clear_mem();
    mem[0] = 16'h1055;
    mem[1] = 16'hD040;
    do_reset();
    stall_addr = 32'h40;
    start_run();
    n = 0;
    while (!(Mem_Rd && Mem_Addr == 12'h40) && n < 50) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    check("mid_rd_hi", 32'(Mem_Rd), 1);
    check("mid_acc", 32'(Acc), 32'h55);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rd_lo", 32'(Mem_Rd), 0);
    check("mid_pc", 32'(Mem_Addr), 0);
    check("mid_acc0", 32'(Acc), 0);
    check("mid_sel", 32'(ALU_Sel), 32'h8);

    // Random programs against the ISA-level model.
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      base = $urandom_range(32'h100, 32'hF00);
      len  = $urandom_range(8, 20);
      gen_prog(base, len);
      do_reset();
      ack_delay = $urandom_range(0, 2);
      start_run();
      wait_halt("rnd");
      cmp_ref("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Fetch/decode/execute sequencer that sits directly upstream of the 16-bit ALU.
- Fetches 16-bit instructions from program memory over a request/acknowledge handshake and drives the ALU's `ALU_Sel`, `A`, `B` and `Cy_In`.
- Captures `ALU_Out`/`CY_Out` one cycle after the ALU's registered evaluation into its accumulator and carry flag.
- Handles jumps, conditional jumps on carry, and halt.

## Interface
- `ADDR_W`, default 12: program counter and memory address width.
- `System_Clk` in 1: single system clock; all state changes on rising edge.
- `System_Rst_n` in 1: asynchronous, active-low reset.
- `Run` in 1: start/resume request, sampled in IDLE and HALTED.
- `Mem_Addr` out ADDR_W: instruction address (= PC).
- `Mem_Rd` out 1: fetch request; held high until acknowledged.
- `Mem_Ack` in 1: memory acknowledge; `Mem_Data` valid in the same cycle.
- `Mem_Data` in 16: instruction word.
- `ALU_Sel` out 4: ALU operation select.
- `Op_A` out 16: ALU A operand (= ACC).
- `Op_B` out 16: ALU B operand (= {4'h0, imm12}).
- `Cy_Flag` out 1: carry flag; drives the ALU `Cy_In`.
- `ALU_Out` in 16: ALU result.
- `CY_Out` in 1: ALU carry out.
- `Acc` out 16: accumulator.
- `Halted` out 1: high while in HALTED.

## Operation
- **Instruction format:** [15:12] opcode, [11:0] imm12.
- **Opcodes 0x0–0xC (ALU operations):**
  - `ALU_Sel` = opcode, `Op_A` = ACC, `Op_B` = imm12 zero-extended.
  - ACC write enable: 0x0–0xA.
  - Cy write enable: 0x0–0x8, 0xB, 0xC. Opcodes 0x9/0xA leave Cy unchanged; 0xB/0xC leave ACC unchanged.
- **Opcode 0xD, JMP:** PC ← imm12[ADDR_W-1:0].
- **Opcode 0xE, JC:** PC ← imm12 if Cy=1, else PC unchanged (already incremented).
- **Opcode 0xF, HALT:** enter HALTED.
- **States and transitions:**
  - IDLE → FETCH on `Run`.
  - FETCH → DECODE on `Mem_Rd & Mem_Ack`.
  - DECODE → EXEC for ALU opcodes; → FETCH for JMP/JC; → HALTED for HALT.
  - EXEC → WB → FETCH.
  - HALTED → FETCH on `Run`.
- **FETCH:** `Mem_Rd`=1. On the ack edge: IR ← `Mem_Data`, PC ← PC+1 mod 2^ADDR_W (0xFFF wraps to 0x000).
- **ALU drive:**
  - In EXEC and WB, `ALU_Sel`/`Op_A`/`Op_B` are registered from IR/ACC and held stable across both cycles.
  - In all other states: `ALU_Sel`=4'b1000, `Op_A`=`Op_B`=0.
- **WB:** on the edge ending WB, ACC and/or Cy are loaded from `ALU_Out`/`CY_Out` per the write enables above.
- **Handshake corner cases:**
  - `Mem_Ack` while `Mem_Rd`=0 is ignored.
  - `Mem_Rd` deasserts the cycle after the ack edge.
  - Fetch waits indefinitely for ack; no timeout.
- **`Run` outside IDLE/HALTED:** ignored.

## Timing
- **Reset values:** PC=0, ACC=0, Cy=0, IR=0, state IDLE, `Mem_Rd`=0, `ALU_Sel`=4'b1000, `Op_A`=`Op_B`=0, `Halted`=0.
- **Reset mid-operation:** takes effect asynchronously, including during FETCH with `Mem_Rd` high. No write-back occurs.
- **ALU instruction:** 3 cycles + fetch wait. With zero-wait memory (ack in the first FETCH cycle), 4 cycles per instruction.
- **JMP/JC:** 2 cycles with zero-wait memory. The new PC appears on `Mem_Addr` in the first FETCH cycle after DECODE.
- **HALT:** `Halted` rises the cycle after DECODE. `Run` in HALTED goes to FETCH next cycle at the current PC, i.e. the address after the HALT.
- **ALU result timing:** the ALU samples its inputs on the edge ending EXEC; its result is valid throughout WB and captured on the edge ending WB.
- **JC timing:** JC uses the Cy value updated by the immediately preceding instruction's WB.

## Structure
- **Package `ev20_seq_pkg`:**
  - Opcode constants (`OP_PASS_A`…`OP_SETC`, `OP_JMP`=4'hD, `OP_JC`=4'hE, `OP_HALT`=4'hF).
  - State enum {IDLE, FETCH, DECODE, EXEC, WB, HALTED}.
  - `ALU_IDLE_SEL`=4'b1000.
- **Sub-module `seq_decode`:** combinational; maps opcode to `alu_sel`, `acc_we`, `cy_we`, `is_jmp`, `is_jc`, `is_halt`.
- **Top level:** holds the FSM, PC, IR, ACC, Cy and the operand registers.

## Test plan
1. **Reset/idle:** reset released, `Run`=0 for 10 cycles → `Mem_Rd`=0, `ALU_Sel`=4'b1000, `Acc`=0, `Halted`=0.
2. **ADD-immediate:** ACC=0x0003, instr 0x4005, zero-wait memory → `ALU_Sel`=0x4 and `Op_B`=0x0005 in EXEC/WB; ACC=0x0008 and Cy=0 after WB; PC=1 from the FETCH onward.
3. **Carry and JC:** ACC=0xFFFF, Cy=0, instrs 0x4001, 0xE020 (with a model ALU) → ACC=0x0000, Cy=1, next `Mem_Addr`=0x020. Repeat with Cy=0 → `Mem_Addr`=0x002.
4. **Flag-only and const-only ops:**
   - 0xC000 → Cy=1, ACC unchanged.
   - 0xA000 → ACC=0xFFFF, Cy unchanged.
5. **Wait states and wrap:**
   - `Mem_Ack` delayed 3 cycles → `Mem_Rd` held 4 cycles, IR loads only on the ack edge.
   - Fetch at PC=0xFFF → PC=0x000.
   - Spurious `Mem_Ack` in IDLE ignored.
6. **Halt/resume and reset mid-fetch:**
   - 0xF000 at 0x010 → `Halted`=1; `Run` pulse → fetch at 0x011.
   - `System_Rst_n` low while `Mem_Rd`=1 → `Mem_Rd`=0 immediately, PC=0.
